// File: rtl/cv32e40p_tb_pkg.sv
// Shared types for the simulation controller: FSM states and status codes.
package cv32e40p_tb_pkg;

    typedef enum logic [1:0] {
        StWait,
        StRun,
        StDone
    } state_e;

    localparam logic [2:0] StatusWait     = 3'd0;
    localparam logic [2:0] StatusRun      = 3'd1;
    localparam logic [2:0] StatusPass     = 3'd2;
    localparam logic [2:0] StatusFail     = 3'd3;
    localparam logic [2:0] StatusExitFail = 3'd4;
    localparam logic [2:0] StatusTimeout  = 3'd5;

endpackage

// File: rtl/cv32e40p_tb_sim_ctrl_if.sv
// Channel report inputs and control/status outputs of the simulation controller.
interface cv32e40p_tb_sim_ctrl_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned EXIT_W = 32
);
    localparam int unsigned FailChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        passed_i;
    logic [NUM_CH-1:0]        failed_i;
    logic [NUM_CH-1:0]        exit_valid_i;
    logic [NUM_CH*EXIT_W-1:0] exit_value_i;
    logic                     core_rst_no;
    logic                     fetch_enable_o;
    logic                     done_o;
    logic [2:0]               status_o;
    logic [FailChW-1:0]       fail_ch_o;
    logic [EXIT_W-1:0]        exit_value_o;
    logic [31:0]              cycle_cnt_o;

    modport master (
        output passed_i, failed_i, exit_valid_i, exit_value_i,
        input  core_rst_no, fetch_enable_o, done_o, status_o, fail_ch_o, exit_value_o,
        input  cycle_cnt_o
    );

    modport slave (
        input  passed_i, failed_i, exit_valid_i, exit_value_i,
        output core_rst_no, fetch_enable_o, done_o, status_o, fail_ch_o, exit_value_o,
        output cycle_cnt_o
    );

endinterface

// File: rtl/cv32e40p_tb_rst_seq.sv
// Holds the cores in reset for RESET_WAIT_CYCLES edges after rst_ni release.
module cv32e40p_tb_rst_seq #(
    parameter int unsigned RESET_WAIT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic core_rst_no,
    output logic rel_o
);
    localparam int unsigned CntW = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(RESET_WAIT_CYCLES - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_core_rst_n;

    // High during the edge on which the cores leave reset.
    assign rel_o       = ~r_core_rst_n & (r_cnt == LastCnt);
    assign core_rst_no = r_core_rst_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt        <= '0;
            r_core_rst_n <= 1'b0;
        end else if (!r_core_rst_n) begin
            if (rel_o) begin
                r_core_rst_n <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_tb_sim_ctrl.sv
// Simulation controller: reset sequencing, channel pass/fail collection, watchdog.
// Watchdog timeout is built only when CV32E40P_TB_WATCHDOG_EN is defined.
module cv32e40p_tb_sim_ctrl
    import cv32e40p_tb_pkg::*;
#(
    parameter int unsigned NUM_CH            = 2,
    parameter int unsigned EXIT_W            = 32,
    parameter int unsigned RESET_WAIT_CYCLES = 4,
    parameter int unsigned MAX_CYCLES        = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cv32e40p_tb_sim_ctrl_if.slave bus
);
    localparam int unsigned FailChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e             r_state, w_state_nxt;
    logic [2:0]         r_status, w_status_nxt;
    logic [FailChW-1:0] r_fail_ch, w_fail_ch_nxt;
    logic [EXIT_W-1:0]  r_exit_value, w_exit_value_nxt;
    logic [31:0]        r_cycle, w_cycle_nxt;
    logic [NUM_CH-1:0]  r_done, w_done_nxt;

    logic               w_rel;
    logic               w_core_rst_n;
    logic               w_timeout;
    logic [NUM_CH-1:0]  w_fail;
    logic [NUM_CH-1:0]  w_done_set;
    logic [FailChW-1:0] w_low;
    logic               w_low_failed;
    logic [EXIT_W-1:0]  w_low_value;

    cv32e40p_tb_rst_seq #(
        .RESET_WAIT_CYCLES (RESET_WAIT_CYCLES)
    ) u_rst_seq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .core_rst_no (w_core_rst_n),
        .rel_o       (w_rel)
    );

`ifdef CV32E40P_TB_WATCHDOG_EN
    assign w_timeout = (MAX_CYCLES != 0) && (r_cycle == 32'(MAX_CYCLES - 1));
`else
    logic w_unused_max;
    assign w_unused_max = ^MAX_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    // Classify channel reports; descending scan leaves the lowest failing index.
    always_comb begin
        w_fail       = '0;
        w_done_set   = '0;
        w_low        = '0;
        w_low_failed = 1'b0;
        w_low_value  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            w_fail[c]     = bus.failed_i[c] |
                            (bus.exit_valid_i[c] & (|bus.exit_value_i[c*EXIT_W +: EXIT_W]));
            w_done_set[c] = bus.passed_i[c] |
                            (bus.exit_valid_i[c] & ~(|bus.exit_value_i[c*EXIT_W +: EXIT_W]));
            if (w_fail[c]) begin
                w_low        = FailChW'(c);
                w_low_failed = bus.failed_i[c];
                w_low_value  = bus.exit_value_i[c*EXIT_W +: EXIT_W];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_status_nxt     = r_status;
        w_fail_ch_nxt    = r_fail_ch;
        w_exit_value_nxt = r_exit_value;
        w_cycle_nxt      = r_cycle;
        w_done_nxt       = r_done;
        unique case (r_state)
            StWait: begin
                if (w_rel) begin
                    w_state_nxt  = StRun;
                    w_status_nxt = StatusRun;
                end
            end
            StRun: begin
                w_done_nxt = r_done | w_done_set;
                if (|w_fail) begin
                    w_state_nxt   = StDone;
                    w_fail_ch_nxt = w_low;
                    if (w_low_failed) begin
                        w_status_nxt     = StatusFail;
                        w_exit_value_nxt = '0;
                    end else begin
                        w_status_nxt     = StatusExitFail;
                        w_exit_value_nxt = w_low_value;
                    end
                end else if (&w_done_nxt) begin
                    w_state_nxt      = StDone;
                    w_status_nxt     = StatusPass;
                    w_fail_ch_nxt    = '0;
                    w_exit_value_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt  = StDone;
                    w_status_nxt = StatusTimeout;
                end else if (r_cycle != '1) begin
                    w_cycle_nxt = r_cycle + 32'd1;
                end
            end
            StDone: ;
            default: w_state_nxt = StWait;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StWait;
            r_status     <= StatusWait;
            r_fail_ch    <= '0;
            r_exit_value <= '0;
            r_cycle      <= '0;
            r_done       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_status     <= w_status_nxt;
            r_fail_ch    <= w_fail_ch_nxt;
            r_exit_value <= w_exit_value_nxt;
            r_cycle      <= w_cycle_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.core_rst_no    = w_core_rst_n;
    assign bus.fetch_enable_o = (r_state == StRun);
    assign bus.done_o         = (r_state == StDone);
    assign bus.status_o       = r_status;
    assign bus.fail_ch_o      = r_fail_ch;
    assign bus.exit_value_o   = r_exit_value;
    assign bus.cycle_cnt_o    = r_cycle;

endmodule
